// File: rtl/obp_program_loader.sv
// Host-to-processor program loader: clears the one-bit NAND processor, shifts instruction words in LSB first, runs, then halts.
// Defining OBP_LOADER_CHECKSUM_EN adds a 16-bit running sum of accepted words on the checksum port.
module obp_program_loader #(
    parameter int INSTR_LEN = 13,
    parameter int MAX_WORDS = 1000,
    parameter int CNT_W     = 10,
    parameter int RUN_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_start,
    input  logic                 cmd_abort,
    input  logic [RUN_W-1:0]     run_cycles,
    input  logic [INSTR_LEN-1:0] word_data,
    input  logic                 word_last,
    input  logic                 word_valid,
    output logic                 word_ready,
    input  logic [1:0]           run_in,
    output logic                 proc_reset,
    output logic                 proc_en,
    output logic [1:0]           proc_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     words_loaded
`ifdef OBP_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]          checksum
`endif
);

    localparam int BIT_W = (INSTR_LEN > 1) ? $clog2(INSTR_LEN) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(INSTR_LEN - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FETCH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4,
        ST_RUN   = 3'd5,
        ST_HALT  = 3'd6
    } state_t;

    state_t               state_r, state_s;
    logic [INSTR_LEN-1:0] sr_r, sr_s;
    logic [BIT_W-1:0]     bit_r, bit_s;
    logic                 last_r, last_s;
    logic [CNT_W-1:0]     words_s;
    logic [RUN_W-1:0]     run_len_r, run_len_s;
    logic [RUN_W-1:0]     run_cnt_r, run_cnt_s;
    logic                 err_s;
    logic                 ready_s;
    logic [1:0]           proc_in_s;
    logic                 hs_s;

    assign hs_s = word_valid && word_ready;

    // Next-state, datapath and next-output decode; abort has priority over every other event.
    always_comb begin
        state_s   = state_r;
        sr_s      = sr_r;
        bit_s     = bit_r;
        last_s    = last_r;
        words_s   = words_loaded;
        run_len_s = run_len_r;
        run_cnt_s = run_cnt_r;
        err_s     = err;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (cmd_start) begin
                    state_s   = ST_CLEAR;
                    run_len_s = run_cycles;
                    err_s     = 1'b0;
                    words_s   = '0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_CLEAR: begin
                if (cmd_abort) begin
                    state_s = ST_HALT;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (cmd_abort) begin
                    state_s = ST_HALT;
                    err_s   = 1'b1;
                end else if (hs_s) begin
                    state_s = ST_SHIFT;
                    sr_s    = word_data;
                    last_s  = word_last;
                    bit_s   = '0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SHIFT: begin
                if (cmd_abort) begin
                    state_s = ST_HALT;
                    err_s   = 1'b1;
                end else if (bit_r == LAST_BIT) begin
                    words_s = words_loaded + CNT_W'(1);
                    if (last_r) begin
                        state_s = ST_GAP;
                    end else if (words_s == MAX_CNT) begin
                        state_s = ST_HALT;
                        err_s   = 1'b1;
                    end else if (hs_s) begin
                        // Back-to-back reload keeps en high: an en edge would restart the processor's load counters.
                        sr_s   = word_data;
                        last_s = word_last;
                        bit_s  = '0;
                    end else begin
                        state_s = ST_HALT;
                        err_s   = 1'b1;
                    end
                end else begin
                    sr_s  = {1'b0, sr_r[INSTR_LEN-1:1]};
                    bit_s = bit_r + BIT_W'(1);
                end
            end
            ST_GAP: begin
                if (cmd_abort) begin
                    state_s = ST_HALT;
                end else begin
                    state_s   = ST_RUN;
                    run_cnt_s = run_len_r;
                end
            end
            ST_RUN: begin
                if (cmd_abort) begin
                    state_s = ST_HALT;
                end else if (run_len_r == '0) begin
                    state_s = ST_RUN;
                end else if (run_cnt_r <= RUN_W'(1)) begin
                    state_s = ST_HALT;
                end else begin
                    run_cnt_s = run_cnt_r - RUN_W'(1);
                end
            end
            default: state_s = ST_IDLE;
        endcase

        // Ready is withheld on the word that fills the memory so no handshake is ever dropped.
        ready_s = (state_s == ST_FETCH) ||
                  ((state_s == ST_SHIFT) && (bit_s == LAST_BIT) && !last_s &&
                   ((words_s + CNT_W'(1)) != MAX_CNT));

        case (state_s)
            ST_SHIFT:       proc_in_s = {1'b0, sr_s[0]};
            ST_GAP, ST_RUN: proc_in_s = run_in;
            default:        proc_in_s = 2'b00;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            sr_r         <= '0;
            bit_r        <= '0;
            last_r       <= 1'b0;
            run_len_r    <= '0;
            run_cnt_r    <= '0;
            word_ready   <= 1'b0;
            proc_reset   <= 1'b0;
            proc_en      <= 1'b0;
            proc_in      <= 2'b00;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            state_r      <= state_s;
            sr_r         <= sr_s;
            bit_r        <= bit_s;
            last_r       <= last_s;
            run_len_r    <= run_len_s;
            run_cnt_r    <= run_cnt_s;
            word_ready   <= ready_s;
            proc_reset   <= (state_s == ST_CLEAR);
            proc_en      <= (state_s == ST_SHIFT) || (state_s == ST_HALT);
            proc_in      <= proc_in_s;
            busy         <= (state_s != ST_IDLE);
            done         <= (state_s == ST_HALT);
            err          <= err_s;
            words_loaded <= words_s;
        end
    end

`ifdef OBP_LOADER_CHECKSUM_EN
    // Running sum of accepted words; a same-cycle abort cancels the handshake so it is not summed.
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= 16'h0000;
        end else if (cmd_start && ((state_r == ST_IDLE) || (state_r == ST_HALT))) begin
            checksum <= 16'h0000;
        end else if (hs_s && !cmd_abort) begin
            checksum <= checksum + 16'(word_data);
        end else begin
            checksum <= checksum;
        end
    end
`endif

endmodule

// File: tb/tb_obp_program_loader.sv
// Self-checking bench for obp_program_loader: scenario table plus hand-written abort/overflow/run-forever/reset sequences.
module tb_obp_program_loader;
    localparam int INSTR_LEN = 13;
    localparam int CNT_W     = 10;
    localparam int RUN_W     = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 cmd_start = 1'b0;
    logic                 cmd_abort = 1'b0;
    logic [RUN_W-1:0]     run_cycles = '0;
    logic [INSTR_LEN-1:0] word_data = '0;
    logic                 word_last = 1'b0;
    logic                 word_valid = 1'b0;
    logic [1:0]           run_in = 2'b00;

    logic word_ready, proc_reset, proc_en, busy, done, err;
    logic [1:0] proc_in;
    logic [CNT_W-1:0] words_loaded;
    logic o_word_ready, o_proc_reset, o_proc_en, o_busy, o_done, o_err;
    logic [1:0] o_proc_in;
    logic [CNT_W-1:0] o_words_loaded;
`ifdef OBP_LOADER_CHECKSUM_EN
    logic [15:0] checksum, o_checksum;
`endif

    always #5 clk = ~clk;

    obp_program_loader dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .run_cycles(run_cycles), .word_data(word_data), .word_last(word_last),
        .word_valid(word_valid), .word_ready(word_ready), .run_in(run_in),
        .proc_reset(proc_reset), .proc_en(proc_en), .proc_in(proc_in),
        .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
`ifdef OBP_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    obp_program_loader #(.MAX_WORDS(4)) dut_ovf (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .run_cycles(run_cycles), .word_data(word_data), .word_last(word_last),
        .word_valid(word_valid), .word_ready(o_word_ready), .run_in(run_in),
        .proc_reset(o_proc_reset), .proc_en(o_proc_en), .proc_in(o_proc_in),
        .busy(o_busy), .done(o_done), .err(o_err), .words_loaded(o_words_loaded)
`ifdef OBP_LOADER_CHECKSUM_EN
        , .checksum(o_checksum)
`endif
    );

    typedef struct {
        int                  nwords;
        logic [8:0][12:0]    w;
        logic                last_flag;
        logic [15:0]         run;
        int                  exp_en;
        int                  exp_low;
        int                  exp_words;
        logic                exp_err;
        logic [15:0]         exp_csum;
    } scen_t;

    int   n_pass  = 0;
    int   n_total = 0;
    logic exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; word_valid = 1'b0;
        word_last = 1'b0; word_data = '0; run_cycles = '0; run_in = 2'b00;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_scen(input scen_t s, input string tag);
        int idx = 0, cyc = 0, en_len = 0, low_len = 0, rst_cnt = 0, first_rst = -1, glitch = 0;
        bit en_ended = 1'b0, prev_en = 1'b0, hs = 1'b0, fin = 1'b0;
        logic [1:0] exp_bits;
        exp_q.delete();
        do_reset();
        cmd_start = 1'b1; run_cycles = s.run; run_in = 2'b01;
        word_valid = 1'b1; word_data = s.w[0]; word_last = (s.nwords == 1) && s.last_flag;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            if (proc_reset) begin
                rst_cnt++;
                if (first_rst < 0) first_rst = cyc;
            end
            if (prev_en && !proc_en) en_ended = 1'b1;
            if (proc_en && !done) begin
                if (en_ended) glitch++;
                en_len++;
                exp_bits = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 2'bxx;
                chk({tag, ".shift_bit"}, 32'(proc_in), 32'(exp_bits));
            end
            if (en_ended && !proc_en && !done) begin
                low_len++;
                chk({tag, ".run_in_pass"}, 32'(proc_in), 32'(run_in));
            end
            prev_en = proc_en;
            hs = word_valid && word_ready;
            if (hs) begin
                for (int b = 0; b < INSTR_LEN; b++) exp_q.push_back(word_data[b]);
            end
            if (done) fin = 1'b1;
            cyc++;
            if (!fin) begin
                @(posedge clk); #1;
                if (hs) begin
                    idx++;
                    if (idx < s.nwords) begin
                        word_data = s.w[idx];
                        word_last = (idx == s.nwords - 1) && s.last_flag;
                    end else begin
                        word_valid = 1'b0;
                        word_last  = 1'b0;
                    end
                end
            end
        end
        chk({tag, ".done"},        32'(done), 32'd1);
        chk({tag, ".err"},         32'(err), 32'(s.exp_err));
        chk({tag, ".words"},       32'(words_loaded), 32'(s.exp_words));
        chk({tag, ".halt_en"},     32'({proc_en, proc_in, word_ready, busy}), 32'b10001);
        chk({tag, ".rst_pulses"},  32'(rst_cnt), 32'd1);
        chk({tag, ".rst_latency"}, 32'(first_rst), 32'd0);
        chk({tag, ".en_len"},      32'(en_len), 32'(s.exp_en));
        chk({tag, ".low_len"},     32'(low_len), 32'(s.exp_low));
        chk({tag, ".en_glitch"},   32'(glitch), 32'd0);
        chk({tag, ".sb_left"},     32'(exp_q.size()), 32'd0);
`ifdef OBP_LOADER_CHECKSUM_EN
        chk({tag, ".checksum"},    32'(checksum), 32'(s.exp_csum));
`endif
    endtask

    initial begin
        scen_t tbl[5];
        int acc;
        bit seen_en;
        for (int i = 0; i < 5; i++) tbl[i].w = '0;
        tbl[0].nwords = 3; tbl[0].w[0] = 13'h1001; tbl[0].w[1] = 13'h0AAA; tbl[0].w[2] = 13'h1FFF;
        tbl[0].last_flag = 1'b1; tbl[0].run = 16'd5;
        tbl[0].exp_en = 39; tbl[0].exp_low = 6; tbl[0].exp_words = 3; tbl[0].exp_err = 1'b0; tbl[0].exp_csum = 16'h3AAA;
        tbl[1].nwords = 1; tbl[1].w[0] = 13'h0ABC; tbl[1].last_flag = 1'b0; tbl[1].run = 16'd5;
        tbl[1].exp_en = 13; tbl[1].exp_low = 0; tbl[1].exp_words = 1; tbl[1].exp_err = 1'b1; tbl[1].exp_csum = 16'h0ABC;
        tbl[2].nwords = 1; tbl[2].w[0] = 13'h0155; tbl[2].last_flag = 1'b1; tbl[2].run = 16'd1;
        tbl[2].exp_en = 13; tbl[2].exp_low = 2; tbl[2].exp_words = 1; tbl[2].exp_err = 1'b0; tbl[2].exp_csum = 16'h0155;
        tbl[3].nwords = 2; tbl[3].w[0] = 13'h1234; tbl[3].w[1] = 13'h0001; tbl[3].last_flag = 1'b1; tbl[3].run = 16'd3;
        tbl[3].exp_en = 26; tbl[3].exp_low = 4; tbl[3].exp_words = 2; tbl[3].exp_err = 1'b0; tbl[3].exp_csum = 16'h1235;
        tbl[4].nwords = 9; for (int i = 0; i < 9; i++) tbl[4].w[i] = 13'h1FFF;
        tbl[4].last_flag = 1'b1; tbl[4].run = 16'd2;
        tbl[4].exp_en = 117; tbl[4].exp_low = 3; tbl[4].exp_words = 9; tbl[4].exp_err = 1'b0; tbl[4].exp_csum = 16'h1FF7;

        // Reset state of both instances.
        do_reset();
        @(negedge clk);
        chk("reset.outs", 32'({word_ready, proc_reset, proc_en, proc_in, busy, done, err}), 32'd0);
        chk("reset.words", 32'(words_loaded), 32'd0);
        chk("reset.ovf_outs", 32'({o_word_ready, o_proc_reset, o_proc_en, o_proc_in, o_busy, o_done, o_err}), 32'd0);

        for (int i = 0; i < 5; i++) run_scen(tbl[i], $sformatf("scen%0d", i));

        // Overflow: MAX_WORDS=4 instance, last never set.
        do_reset();
        cmd_start = 1'b1; run_cycles = 16'd5; word_valid = 1'b1; word_data = 13'h0F0F; word_last = 1'b0;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        acc = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (o_done) break;
            if (word_valid && o_word_ready) acc++;
        end
        chk("ovf.done",     32'(o_done), 32'd1);
        chk("ovf.err",      32'(o_err), 32'd1);
        chk("ovf.words",    32'(o_words_loaded), 32'd4);
        chk("ovf.en",       32'(o_proc_en), 32'd1);
        chk("ovf.accepted", 32'(acc), 32'd4);

        // Abort in the middle of SHIFT, then restart.
        do_reset();
        cmd_start = 1'b1; run_cycles = 16'd5; word_valid = 1'b1; word_data = 13'h1555; word_last = 1'b0;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (word_valid && word_ready) break;
        end
        @(posedge clk); #1;
        word_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("abort.in_shift", 32'({proc_en, done}), 32'b10);
        @(posedge clk); #1;
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        @(negedge clk);
        chk("abort.halt", 32'({done, err, proc_en, busy}), 32'b1111);
        @(posedge clk); #1;
        cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        @(negedge clk);
        chk("restart.clear", 32'({proc_reset, err, done, proc_en}), 32'b1000);
        chk("restart.words", 32'(words_loaded), 32'd0);
        @(negedge clk);
        chk("restart.fetch", 32'({proc_reset, word_ready}), 32'b01);

        // run_cycles = 0: run until abort.
        do_reset();
        run_in = 2'b10; cmd_start = 1'b1; run_cycles = 16'd0;
        word_valid = 1'b1; word_data = 13'h0155; word_last = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        seen_en = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (proc_en) seen_en = 1'b1;
            if (seen_en && !proc_en) break;
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            chk("run0.hold", 32'({done, proc_en, proc_in}), 32'b0010);
        end
        @(posedge clk); #1;
        cmd_abort = 1'b1;
        @(posedge clk); #1;
        cmd_abort = 1'b0;
        @(negedge clk);
        chk("run0.abort", 32'({done, err, proc_en}), 32'b101);

        // Reset mid-load returns to IDLE.
        do_reset();
        cmd_start = 1'b1; run_cycles = 16'd3; word_valid = 1'b1; word_data = 13'h0777; word_last = 1'b0;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("midreset.busy_before", 32'({busy, proc_en}), 32'b11);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset.outs", 32'({word_ready, proc_reset, proc_en, proc_in, busy, done, err}), 32'd0);
        chk("midreset.words", 32'(words_loaded), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
